// File: rtl/scope_pkg.sv
// Shared types and constants for the capture framer: FSM states, trigger modes,
// frame header byte and the layout of the settings control byte.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CAPTURE,
        SEND_HDR,
        SEND_CFG,
        SEND_DATA,
        SEND_SUM,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10,
        SINGLE = 2'b11
    } mode_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    localparam int unsigned SET_EN_BIT   = 0;
    localparam int unsigned SET_MODE_LSB = 1;
    localparam int unsigned SET_MODE_MSB = 2;
    localparam int unsigned SET_TRIG_LSB = 3;
    localparam int unsigned SET_TRIG_MSB = 7;

    // Bytes needed to carry one sample, LSB first.
    function automatic int unsigned bytes_per_sample(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// Simple dual-port sample store: one write per strobe covers all channels of a
// sample index, single-word read port with one cycle of latency.
module frame_buffer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMPLE_W  = 12,
    parameter int unsigned FRAME_LEN = 64,
    localparam int unsigned DEPTH    = FRAME_LEN * NUM_CH,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_row,
    input  logic [NUM_CH*SAMPLE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [SAMPLE_W-1:0]        rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    // Words are laid out index-major so the read side can walk addresses linearly.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem[ADDR_W'(int'(wr_row) * NUM_CH + c)] <= wr_data[c*SAMPLE_W +: SAMPLE_W];
            end
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/capture_framer.sv
// Triggered multi-channel sample capture that serialises each frame as
// header, settings byte, little-endian samples and an XOR checksum.
module capture_framer
    import scope_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMPLE_W  = 12,
    parameter int unsigned FRAME_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 settings,
    input  logic [SAMPLE_W-1:0]        trig_level,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] samples,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned DEPTH  = FRAME_LEN * NUM_CH;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned BPS    = bytes_per_sample(SAMPLE_W);
    localparam int unsigned BSEL_W = (BPS > 1) ? $clog2(BPS) : 1;

    state_t              state, state_nxt;
    logic [7:0]          settings_q, settings_q_nxt;
    logic [SAMPLE_W-1:0] level_q, level_q_nxt;
    logic [SAMPLE_W-1:0] prev, prev_nxt;
    logic                have_prev, have_prev_nxt;
    logic [IDX_W-1:0]    sample_idx, sample_idx_nxt;
    logic [ADDR_W-1:0]   word_ptr, word_ptr_nxt;
    logic [BSEL_W-1:0]   byte_sel, byte_sel_nxt;
    logic                data_last, data_last_nxt;
    logic [7:0]          csum, csum_nxt;
    logic [7:0]          tx_data_nxt;
    logic                tx_valid_nxt;
    logic                overrun_nxt;

    logic                wr_en_c;
    logic [IDX_W-1:0]    wr_row_c;
    logic [SAMPLE_W-1:0] rd_data;
    logic [BPS*8-1:0]    rd_ext;
    logic [7:0]          data_byte;
    logic [ADDR_W-1:0]   ptr_adv;
    logic [BSEL_W-1:0]   sel_adv;
    logic                last_load_c;
    logic [4:0]          trig_sel;
    logic [SAMPLE_W-1:0] trig_curr;
    logic                trig_hit_c;
    logic                enable_c;
    logic                take_c;
    mode_t               mode_q;

    frame_buffer #(
        .NUM_CH    (NUM_CH),
        .SAMPLE_W  (SAMPLE_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_row  (wr_row_c),
        .wr_data (samples),
        .rd_addr (word_ptr_nxt),
        .rd_data (rd_data)
    );

    assign enable_c = settings[SET_EN_BIT];
    assign mode_q   = mode_t'(settings_q[SET_MODE_MSB:SET_MODE_LSB]);
    assign take_c   = tx_valid && tx_ready;

    // Trigger source (out-of-range channel falls back to 0) and edge detection.
    always_comb begin
        trig_sel  = settings_q[SET_TRIG_MSB:SET_TRIG_LSB];
        trig_curr = samples[SAMPLE_W-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
            if (trig_sel == 5'(c)) begin
                trig_curr = samples[c*SAMPLE_W +: SAMPLE_W];
            end
        end
        if (mode_q == FALL) begin
            trig_hit_c = (prev >= level_q) && (trig_curr < level_q);
        end else begin
            trig_hit_c = (prev < level_q) && (trig_curr >= level_q);
        end
    end

    // Byte selection from the buffered word and read-pointer advance.
    always_comb begin
        rd_ext    = (BPS*8)'(rd_data);
        data_byte = rd_ext[7:0];
        for (int b = 0; b < BPS; b++) begin
            if (byte_sel == BSEL_W'(b)) begin
                data_byte = rd_ext[b*8 +: 8];
            end
        end
        last_load_c = (word_ptr == ADDR_W'(DEPTH - 1)) && (byte_sel == BSEL_W'(BPS - 1));
        if (byte_sel == BSEL_W'(BPS - 1)) begin
            ptr_adv = word_ptr + ADDR_W'(1);
            sel_adv = '0;
        end else begin
            ptr_adv = word_ptr;
            sel_adv = byte_sel + BSEL_W'(1);
        end
    end

    always_comb begin
        state_nxt      = state;
        settings_q_nxt = settings_q;
        level_q_nxt    = level_q;
        prev_nxt       = prev;
        have_prev_nxt  = have_prev;
        sample_idx_nxt = sample_idx;
        word_ptr_nxt   = word_ptr;
        byte_sel_nxt   = byte_sel;
        data_last_nxt  = data_last;
        csum_nxt       = csum;
        tx_data_nxt    = tx_data;
        tx_valid_nxt   = tx_valid;
        overrun_nxt    = overrun;
        wr_en_c        = 1'b0;
        wr_row_c       = sample_idx;

        case (state)
            IDLE: begin
                if (enable_c) begin
                    state_nxt      = ARMED;
                    settings_q_nxt = settings;
                    level_q_nxt    = trig_level;
                    have_prev_nxt  = 1'b0;
                    overrun_nxt    = 1'b0;
                end else if (sample_valid) begin
                    overrun_nxt = 1'b1;
                end
            end
            ARMED: begin
                if (!enable_c) begin
                    state_nxt = IDLE;
                end else if (mode_q == FREE) begin
                    state_nxt      = CAPTURE;
                    sample_idx_nxt = '0;
                end else if (sample_valid) begin
                    prev_nxt      = trig_curr;
                    have_prev_nxt = 1'b1;
                    // The triggering sample itself becomes frame sample 0.
                    if (have_prev && trig_hit_c) begin
                        wr_en_c        = 1'b1;
                        wr_row_c       = '0;
                        sample_idx_nxt = IDX_W'(1);
                        state_nxt      = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!enable_c) begin
                    state_nxt = IDLE;
                end else if (sample_valid) begin
                    wr_en_c        = 1'b1;
                    sample_idx_nxt = sample_idx + IDX_W'(1);
                    if (sample_idx == IDX_W'(FRAME_LEN - 1)) begin
                        state_nxt     = SEND_HDR;
                        word_ptr_nxt  = '0;
                        byte_sel_nxt  = '0;
                        data_last_nxt = 1'b0;
                    end
                end
            end
            SEND_HDR: begin
                overrun_nxt = overrun | sample_valid;
                if (!tx_valid) begin
                    tx_data_nxt  = FRAME_HDR;
                    tx_valid_nxt = 1'b1;
                    csum_nxt     = FRAME_HDR;
                end else if (take_c) begin
                    tx_data_nxt = settings_q;
                    csum_nxt    = csum ^ settings_q;
                    state_nxt   = SEND_CFG;
                end
            end
            SEND_CFG, SEND_DATA: begin
                overrun_nxt = overrun | sample_valid;
                if (take_c) begin
                    if (state == SEND_DATA && data_last) begin
                        tx_data_nxt = csum;
                        state_nxt   = SEND_SUM;
                    end else begin
                        tx_data_nxt   = data_byte;
                        csum_nxt      = csum ^ data_byte;
                        word_ptr_nxt  = ptr_adv;
                        byte_sel_nxt  = sel_adv;
                        data_last_nxt = last_load_c;
                        state_nxt     = SEND_DATA;
                    end
                end
            end
            SEND_SUM: begin
                overrun_nxt = overrun | sample_valid;
                if (take_c) begin
                    tx_valid_nxt  = 1'b0;
                    have_prev_nxt = 1'b0;
                    if (mode_q == SINGLE) begin
                        state_nxt = DONE;
                    end else if (enable_c) begin
                        state_nxt = ARMED;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DONE: begin
                overrun_nxt = overrun | sample_valid;
                if (!enable_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settings_q <= '0;
            level_q    <= '0;
            prev       <= '0;
            have_prev  <= 1'b0;
            sample_idx <= '0;
            word_ptr   <= '0;
            byte_sel   <= '0;
            data_last  <= 1'b0;
            csum       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            settings_q <= settings_q_nxt;
            level_q    <= level_q_nxt;
            prev       <= prev_nxt;
            have_prev  <= have_prev_nxt;
            sample_idx <= sample_idx_nxt;
            word_ptr   <= word_ptr_nxt;
            byte_sel   <= byte_sel_nxt;
            data_last  <= data_last_nxt;
            csum       <= csum_nxt;
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            busy       <= !(state_nxt inside {IDLE, DONE});
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_capture_framer.sv
// Directed bench for capture_framer with a small 2-channel, 4-sample frame.
module tb_capture_framer;

    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned NBYTES    = 19;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [7:0]                 settings;
    logic [SAMPLE_W-1:0]        trig_level;
    logic                       sample_valid;
    logic [NUM_CH*SAMPLE_W-1:0] samples;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       busy;
    logic                       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] rxq[$];

    logic [7:0] exp_ramp  [NBYTES] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h00,
                                       8'h01, 8'h08, 8'h02, 8'h00, 8'h02, 8'h08, 8'h03, 8'h00,
                                       8'h03, 8'h08, 8'hA4};
    logic [7:0] exp_rise  [NBYTES] = '{8'hA5, 8'h03, 8'h00, 8'h04, 8'h23, 8'h01, 8'h01, 8'h04,
                                       8'h23, 8'h01, 8'h02, 8'h04, 8'h23, 8'h01, 8'h03, 8'h04,
                                       8'h23, 8'h01, 8'hA6};
    logic [7:0] exp_single[NBYTES] = '{8'hA5, 8'h07, 8'h00, 8'h04, 8'h23, 8'h01, 8'h01, 8'h04,
                                       8'h23, 8'h01, 8'h02, 8'h04, 8'h23, 8'h01, 8'h03, 8'h04,
                                       8'h23, 8'h01, 8'hA2};

    capture_framer #(
        .NUM_CH    (NUM_CH),
        .SAMPLE_W  (SAMPLE_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .settings     (settings),
        .trig_level   (trig_level),
        .sample_valid (sample_valid),
        .samples      (samples),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) rxq.push_back(tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [SAMPLE_W-1:0] a, input logic [SAMPLE_W-1:0] b);
        samples      = {b, a};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (rxq.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_reached"}, 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] expf [NBYTES], input string tag);
        chk({tag, "_len"}, 32'(rxq.size()), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(rxq[i]), 32'(expf[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        int         k;

        reset = 1'b1; settings = 8'h00; trig_level = '0;
        sample_valid = 1'b0; samples = '0; tx_ready = 1'b0;
        cyc(3);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        reset = 1'b0;
        cyc(1);

        // Free-run ramp with the transmitter always ready.
        tx_ready = 1'b1; settings = 8'h01;
        cyc(3);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 4; n++) push(12'(n), 12'(12'h800 + n));
        wait_bytes(NBYTES, "t1");
        cyc(3);
        check_frame(exp_ramp, "t1");
        chk("t1_overrun", 32'(overrun), 32'd0);
        settings = 8'h00;
        cyc(2);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Same frame with a randomly stalling transmitter.
        rxq.delete(); tx_ready = 1'b0; settings = 8'h01;
        cyc(3);
        for (int n = 0; n < 4; n++) push(12'(n), 12'(12'h800 + n));
        pv = 1'b0; pr = 1'b1; pd = 8'h00; k = 0;
        while (rxq.size() < NBYTES && k < 2000) begin
            if (pv && !pr) begin
                chk("t2_stall_valid", 32'(tx_valid), 32'd1);
                chk("t2_stall_data",  32'(tx_data),  32'(pd));
            end
            pv = tx_valid; pd = tx_data;
            tx_ready = 1'($urandom_range(0, 1));
            pr = tx_ready;
            @(negedge clk);
            k++;
        end
        tx_ready = 1'b1;
        cyc(3);
        check_frame(exp_ramp, "t2");
        settings = 8'h00;
        cyc(2);

        // Rising trigger at 0x400 with an overrun injected during the data bytes.
        rxq.delete(); trig_level = 12'h400; settings = 8'h03;
        cyc(1);
        trig_level = 12'hFFF;
        push(12'h500, 12'h123); push(12'h501, 12'h123); push(12'h502, 12'h123);
        cyc(2);
        chk("t3_no_trig_bytes", 32'(rxq.size()), 32'd0);
        chk("t3_no_trig_valid", 32'(tx_valid), 32'd0);
        push(12'h3FF, 12'h123); push(12'h400, 12'h123); push(12'h401, 12'h123);
        push(12'h402, 12'h123); push(12'h403, 12'h123);
        wait_bytes(4, "t3_pre");
        push(12'hFFF, 12'hFFF);
        chk("t3_overrun_set", 32'(overrun), 32'd1);
        wait_bytes(NBYTES, "t3");
        cyc(3);
        check_frame(exp_rise, "t3");
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);
        settings = 8'h00;
        cyc(2);
        chk("t3_idle_busy", 32'(busy), 32'd0);
        settings = 8'h03;
        cyc(2);
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        settings = 8'h00;
        cyc(2);

        // Single-shot: one frame, then DONE until enable drops.
        rxq.delete(); trig_level = 12'h400; settings = 8'h07;
        cyc(1);
        push(12'h3FF, 12'h123); push(12'h400, 12'h123); push(12'h401, 12'h123);
        push(12'h402, 12'h123); push(12'h403, 12'h123);
        wait_bytes(NBYTES, "t4");
        cyc(3);
        check_frame(exp_single, "t4");
        chk("t4_done_busy", 32'(busy), 32'd0);
        chk("t4_overrun0", 32'(overrun), 32'd0);
        push(12'h3FF, 12'h123); push(12'h400, 12'h123); push(12'h401, 12'h123);
        push(12'h402, 12'h123); push(12'h403, 12'h123);
        cyc(20);
        chk("t4_no_second", 32'(rxq.size()), 32'(NBYTES));
        chk("t4_done_overrun", 32'(overrun), 32'd1);
        chk("t4_done_busy2", 32'(busy), 32'd0);
        settings = 8'h00;
        cyc(2);
        settings = 8'h01;
        cyc(2);
        chk("t4_rearm_busy", 32'(busy), 32'd1);
        chk("t4_rearm_overrun", 32'(overrun), 32'd0);
        settings = 8'h00;
        cyc(2);

        // Abort during capture, then reset during data transmission.
        rxq.delete(); settings = 8'h01;
        cyc(3);
        push(12'h000, 12'h800); push(12'h001, 12'h801);
        settings = 8'h00;
        cyc(1);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        cyc(10);
        chk("t5_abort_bytes", 32'(rxq.size()), 32'd0);
        chk("t5_abort_valid", 32'(tx_valid), 32'd0);
        settings = 8'h01;
        cyc(3);
        for (int n = 0; n < 4; n++) push(12'(n), 12'(12'h800 + n));
        wait_bytes(5, "t5_send");
        chk("t5_pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1; settings = 8'h00;
        cyc(1);
        chk("t5_rst_valid", 32'(tx_valid), 32'd0);
        chk("t5_rst_data",  32'(tx_data),  32'h00);
        chk("t5_rst_busy",  32'(busy),     32'd0);
        reset = 1'b0;
        cyc(10);
        chk("t5_rst_bytes", 32'(rxq.size()), 32'd5);
        chk("t5_rst_idle_valid", 32'(tx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/capture_framer.md
CAPTURE_FRAMER -- requirements
Module: capture_framer

Interface
REQ-001 Parameter NUM_CH, default 2, number of analog channels captured in parallel (1..8).
REQ-002 Parameter SAMPLE_W, default 12, bits per sample (1..16).
REQ-003 Parameter FRAME_LEN, default 64, samples per channel per frame (power of two, 4..1024).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 settings  in  8  control byte: bit0 enable, bits2:1 mode, bits7:3 trigger channel.
REQ-008 trig_level  in  SAMPLE_W  unsigned trigger threshold.
REQ-009 sample_valid  in  1  one-cycle strobe qualifying samples.
REQ-010 samples  in  NUM_CH x SAMPLE_W  packed unsigned samples, channel 0 in the low slot.
REQ-011 tx_data  out  8  frame byte to the serial transmitter.
REQ-012 tx_valid  out  1  tx_data holds a valid byte.
REQ-013 tx_ready  in  1  transmitter accepts tx_data this cycle.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 overrun  out  1  sticky: a sample_valid arrived while not accepting samples.

Function
REQ-016 States: IDLE, ARMED, CAPTURE, SEND_HDR, SEND_CFG, SEND_DATA, SEND_SUM, DONE.
REQ-017 IDLE -> ARMED on the cycle enable=1; settings and trig_level are latched on that transition and held for the whole frame.
REQ-018 Mode 00 free-run: ARMED -> CAPTURE immediately; the first accepted sample is the first valid sample in CAPTURE.
REQ-019 Mode 01 rising: trigger when prev < trig_level and curr >= trig_level on the trigger channel; mode 10 falling: prev >= level, curr < level; mode 11 single-shot, rising.
REQ-020 Trigger requires two consecutive valid samples after arming; the triggering sample is frame sample 0.
REQ-021 Trigger channel index >= NUM_CH selects channel 0.
REQ-022 CAPTURE stores every valid sample of all channels; after sample FRAME_LEN-1 it goes to SEND_HDR on the next cycle.
REQ-023 Byte order: 0xA5, latched settings byte, samples (index ascending, channel ascending within index), XOR checksum of all preceding bytes including 0xA5.
REQ-024 Each sample occupies BPS = ceil(SAMPLE_W/8) bytes, LSB first, zero-extended.
REQ-025 Frame length is 3 + FRAME_LEN*NUM_CH*BPS bytes (default 259).
REQ-026 A byte transfers when tx_valid and tx_ready are both 1; tx_data and tx_valid are registered and stay stable while tx_valid=1 and tx_ready=0.
REQ-027 tx_valid goes high one cycle after entering SEND_HDR; back-to-back bytes transfer on consecutive cycles when tx_ready is held high.
REQ-028 After the checksum transfers: modes 00/01/10 return to ARMED if enable=1, else IDLE; mode 11 enters DONE.
REQ-029 DONE holds until enable=0, then goes to IDLE.
REQ-030 enable=0 in ARMED or CAPTURE aborts to IDLE on the next cycle; no bytes are emitted.
REQ-031 enable=0 in any SEND state is ignored until the checksum transfers; frames are never truncated.
REQ-032 sample_valid in any SEND state, DONE or IDLE sets overrun; the sample is dropped.
REQ-033 overrun is cleared on reset and on each IDLE -> ARMED transition.
REQ-034 Settings changes after arming do not affect the frame in progress.

Reset
REQ-035 Reset forces IDLE; tx_valid=0, tx_data=0x00, busy=0, overrun=0; the checksum and all counters clear.
REQ-036 Reset mid-frame abandons the frame without emitting further bytes; buffer contents need not be cleared.

Structure
REQ-037 Package scope_pkg holds the state enum, mode enum (FREE, RISE, FALL, SINGLE), FRAME_HDR=8'hA5 and the settings-field bit positions.
REQ-038 Sub-module frame_buffer: simple dual-port RAM, depth FRAME_LEN*NUM_CH, width SAMPLE_W, one-cycle read latency, no reset on storage.

Verification
REQ-039 NUM_CH=2, SAMPLE_W=12, FRAME_LEN=4, mode 00, ramp samples ch0=n, ch1=0x800+n, tx_ready=1 -> 19 bytes A5,01,00,00,00,08,01,00,01,08,... with the correct XOR checksum.
REQ-040 Mode 01, level 0x400, ch0 sequence 0x3FF, 0x400 -> frame sample 0 equals 0x400; a sequence starting at 0x500 does not trigger.
REQ-041 tx_ready toggled randomly -> tx_data stable while stalled; byte sequence identical to the REQ-039 case.
REQ-042 sample_valid during SEND_DATA -> overrun=1, frame content unchanged; overrun clears on re-arm.
REQ-043 Mode 11 -> exactly one frame, then DONE with busy=0; after enable drops, IDLE.
REQ-044 enable=0 mid-CAPTURE -> IDLE next cycle, no tx_valid; reset mid-SEND_DATA -> tx_valid=0 on the next cycle.
